pe_row_ctrl: RTL and testbench
==============================

Name: pe_row_ctrl

Overview:
Sequencer for one PE row (MATRIX_SIZE multipliers plus adder tree). It accepts a weight vector, pulses the row's weight_reload, and streams a programmed number of data vectors into the row. It then tracks the row's fixed pipeline latency so that out_valid marks each dot-product result, and signals done when the job has fully drained. It sits between the tile-level scheduler/buffers and the PE row.

Parameters:
DATA_BW, 8, bits per data element
WEIGHT_BW, 8, bits per weight element
MATRIX_SIZE, 8, elements per vector
PARTIAL_SUM_BW, 20, width of row result
PIPE_LAT, 2, cycles from pe_data_in change to matching pe_data_out (0 = combinational)
CNT_BW, 16, width of vector counter

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  job start, sampled only in IDLE
num_vec  in  CNT_BW  data vectors in job, latched on start
wt_valid  in  1  weight vector valid
wt_ready  out  1  controller accepts weight vector
wt_data  in  WEIGHT_BW*MATRIX_SIZE  packed weights, element i at [i*WEIGHT_BW +: WEIGHT_BW]
in_valid  in  1  data vector valid
in_ready  out  1  controller accepts data vector
in_data  in  DATA_BW*MATRIX_SIZE  packed data vector
pe_weight_reload  out  1  to row weight_reload
pe_weights  out  WEIGHT_BW*MATRIX_SIZE  to row weights (registered)
pe_data_in  out  DATA_BW*MATRIX_SIZE  to row data_in (registered)
pe_data_out  in  PARTIAL_SUM_BW  signed row result
out_valid  out  1  out_data holds a job result this cycle
out_data  out  PARTIAL_SUM_BW  combinational passthrough of pe_data_out
busy  out  1  high in every state except IDLE
done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset (async, rstn=0): state=IDLE. wt_ready, in_ready, pe_weight_reload, out_valid, busy and done are 0. pe_weights, pe_data_in, vector counters and the valid shift register are 0. Reset mid-job aborts immediately; no done is produced.
- States: IDLE, LOAD_W, RELOAD, STREAM, DRAIN, DONE.
- IDLE: start=1 and num_vec!=0 -> latch num_vec, go to LOAD_W. start=1 and num_vec==0 -> go to DONE. start in any other state is ignored.
- LOAD_W: wt_ready=1. On wt_valid&wt_ready, pe_weights<=wt_data, then go to RELOAD.
- RELOAD: exactly 1 cycle. pe_weight_reload=1 with pe_weights stable, wt_ready=0, in_ready=0. Then go to STREAM.
- STREAM: in_ready=1. A handshake at cycle t sets pe_data_in<=in_data at t+1, increments the accepted count and pushes 1 into the valid shift register. A cycle without a handshake loads pe_data_in<=0 and pushes 0. The handshake on vector num_vec sets in_ready=0 from the next cycle and moves to DRAIN.
- Valid alignment: a vector accepted at t gives out_valid=1 at exactly t+1+PIPE_LAT. Bubbles on in_valid propagate as out_valid=0 gaps.
- The output has no backpressure; the consumer must always accept.
- DRAIN: in_ready=0. Stay until the last out_valid has been issued, then go to DONE on the next cycle.
- DONE: done=1 and busy=1 for 1 cycle, then go to IDLE. For num_vec==0 with start at t, done=1 at t+1 and no weight or data handshake occurs.
- pe_weights holds its value after the job, because the row keeps stale weights until the next reload.
- Counter: accepted count compares against latched num_vec. num_vec up to 2^CNT_BW-1 needs no wrap handling.

Test Plan:
- Reset: hold rstn=0 with random inputs -> all outputs 0, state IDLE. Release rstn -> still idle, busy=0.
- Basic job (PIPE_LAT=2, behavioural row model): weights all 1, num_vec=3, data all 2, in_valid held high -> one pe_weight_reload pulse before the first in_ready. Three consecutive out_valid with out_data=16, the first at 3 cycles after the first accept. done 1 cycle after the last out_valid.
- Bubbles: num_vec=4, in_valid low for 2 cycles between vectors 2 and 3. Weights {1..8}, data all 1 -> out_data=36 four times, with a 2-cycle out_valid gap matching the input gap.
- Zero-length: start with num_vec=0 -> done at next cycle. wt_ready, in_ready and pe_weight_reload stay 0.
- Reset mid-STREAM: after 2 of 5 vectors accepted, pulse rstn low -> outputs 0 immediately, no done. A new job with num_vec=1 then completes normally.
- Back-to-back: pulse start while busy -> ignored. After done, a second job with weights all -1 and data all 3 -> a new reload pulse, then out_data=-24.

Source files
------------

// File: rtl/pe_row_ctrl.sv
// Sequencer for one PE row: loads a weight vector, pulses the row reload, streams
// the job's data vectors and tracks the row pipeline so results are flagged valid.
module pe_row_ctrl #(
    parameter int DATA_BW        = 8,
    parameter int WEIGHT_BW      = 8,
    parameter int MATRIX_SIZE    = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int PIPE_LAT       = 2,
    parameter int CNT_BW         = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_start,
    input  logic [CNT_BW-1:0]               i_num_vec,
    input  logic                            i_wt_valid,
    output logic                            o_wt_ready,
    input  logic [WEIGHT_BW*MATRIX_SIZE-1:0] i_wt_data,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic [DATA_BW*MATRIX_SIZE-1:0]  i_in_data,
    output logic                            o_pe_weight_reload,
    output logic [WEIGHT_BW*MATRIX_SIZE-1:0] o_pe_weights,
    output logic [DATA_BW*MATRIX_SIZE-1:0]  o_pe_data_in,
    input  logic [PARTIAL_SUM_BW-1:0]       i_pe_data_out,
    output logic                            o_out_valid,
    output logic [PARTIAL_SUM_BW-1:0]       o_out_data,
    output logic                            o_busy,
    output logic                            o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_RELOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [PIPE_LAT:0] TOP_MASK = (PIPE_LAT + 1)'(1) << PIPE_LAT;

    state_t                           r_state;
    logic [CNT_BW-1:0]                r_num_vec;
    logic [CNT_BW-1:0]                r_cnt;
    logic [PIPE_LAT:0]                r_vld;
    logic                             r_wt_ready;
    logic                             r_in_ready;
    logic                             r_reload;
    logic                             r_busy;
    logic                             r_done;
    logic [WEIGHT_BW*MATRIX_SIZE-1:0] r_pe_weights;
    logic [DATA_BW*MATRIX_SIZE-1:0]   r_pe_data_in;

    logic                             w_wt_hs;
    logic                             w_in_hs;
    logic                             w_last_vec;
    logic                             w_pending;

    assign w_wt_hs    = i_wt_valid & r_wt_ready;
    assign w_in_hs    = i_in_valid & r_in_ready;
    assign w_last_vec = (r_cnt == (r_num_vec - CNT_BW'(1)));
    // Results still in flight behind the one (if any) leaving the row this cycle.
    assign w_pending  = |(r_vld & ~TOP_MASK);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_num_vec    <= '0;
            r_cnt        <= '0;
            r_vld        <= '0;
            r_wt_ready   <= 1'b0;
            r_in_ready   <= 1'b0;
            r_reload     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pe_weights <= '0;
            r_pe_data_in <= '0;
        end else begin
            r_reload     <= 1'b0;
            r_done       <= 1'b0;
            r_pe_data_in <= w_in_hs ? i_in_data : '0;
            r_vld[0]     <= w_in_hs;
            for (int i = 1; i <= PIPE_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_busy <= 1'b1;
                        if (i_num_vec != '0) begin
                            r_num_vec  <= i_num_vec;
                            r_cnt      <= '0;
                            r_wt_ready <= 1'b1;
                            r_state    <= S_LOAD_W;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_LOAD_W: begin
                    if (w_wt_hs) begin
                        r_pe_weights <= i_wt_data;
                        r_wt_ready   <= 1'b0;
                        r_reload     <= 1'b1;
                        r_state      <= S_RELOAD;
                    end
                end
                S_RELOAD: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_in_hs) begin
                        r_cnt <= r_cnt + CNT_BW'(1);
                        if (w_last_vec) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_pending) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_wt_ready         = r_wt_ready;
    assign o_in_ready         = r_in_ready;
    assign o_pe_weight_reload = r_reload;
    assign o_pe_weights       = r_pe_weights;
    assign o_pe_data_in       = r_pe_data_in;
    assign o_out_valid        = r_vld[PIPE_LAT];
    assign o_out_data         = i_pe_data_out;
    assign o_busy             = r_busy;
    assign o_done             = r_done;

endmodule

// File: tb/tb_pe_row_ctrl.sv
// Directed bench for pe_row_ctrl with a behavioural PE row and a result scoreboard
// that also checks each result arrives in its exact cycle.
module tb_pe_row_ctrl;

    localparam int DATA_BW        = 8;
    localparam int WEIGHT_BW      = 8;
    localparam int MATRIX_SIZE    = 8;
    localparam int PARTIAL_SUM_BW = 20;
    localparam int PIPE_LAT       = 2;
    localparam int CNT_BW         = 16;
    localparam int VW             = DATA_BW * MATRIX_SIZE;
    localparam int WW             = WEIGHT_BW * MATRIX_SIZE;

    typedef struct {
        logic [PARTIAL_SUM_BW-1:0] value;
        int                        cyc;
    } expEntry_t;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      start;
    logic [CNT_BW-1:0]         numVec;
    logic                      wtValid;
    logic                      wtReady;
    logic [WW-1:0]             wtData;
    logic                      inValid;
    logic                      inReady;
    logic [VW-1:0]             inData;
    logic                      peReload;
    logic [WW-1:0]             peWeights;
    logic [VW-1:0]             peDataIn;
    logic [PARTIAL_SUM_BW-1:0] peDataOut;
    logic                      outValid;
    logic [PARTIAL_SUM_BW-1:0] outData;
    logic                      busy;
    logic                      done;

    int        nChecks = 0;
    int        nPass   = 0;
    int        cyc     = 0;
    int        nOut    = 0;
    int        nDone   = 0;
    int        lastOutCyc = 0;
    logic [WW-1:0] tbWeights = '0;
    expEntry_t sb[$];

    logic [PARTIAL_SUM_BW-1:0] rowS1, rowS2;

    pe_row_ctrl #(
        .DATA_BW(DATA_BW), .WEIGHT_BW(WEIGHT_BW), .MATRIX_SIZE(MATRIX_SIZE),
        .PARTIAL_SUM_BW(PARTIAL_SUM_BW), .PIPE_LAT(PIPE_LAT), .CNT_BW(CNT_BW)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_num_vec(numVec),
        .i_wt_valid(wtValid), .o_wt_ready(wtReady), .i_wt_data(wtData),
        .i_in_valid(inValid), .o_in_ready(inReady), .i_in_data(inData),
        .o_pe_weight_reload(peReload), .o_pe_weights(peWeights),
        .o_pe_data_in(peDataIn), .i_pe_data_out(peDataOut),
        .o_out_valid(outValid), .o_out_data(outData),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [PARTIAL_SUM_BW-1:0] dotProduct(input logic [WW-1:0] w, input logic [VW-1:0] d);
        logic signed [PARTIAL_SUM_BW-1:0] acc;
        acc = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            acc = acc + PARTIAL_SUM_BW'($signed(w[i*WEIGHT_BW +: WEIGHT_BW]) * $signed(d[i*DATA_BW +: DATA_BW]));
        end
        return acc;
    endfunction

    // Behavioural row: two register stages after the data_in register.
    always @(posedge clk) begin
        rowS1 <= dotProduct(peWeights, peDataIn);
        rowS2 <= rowS1;
    end
    assign peDataOut = rowS2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Scoreboard: push on each accepted data vector, pop on each out_valid.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (inValid && inReady)
                sb.push_back('{dotProduct(tbWeights, inData), cyc + 1 + PIPE_LAT});
            if (done === 1'b1) nDone++;
            if (outValid === 1'b1) begin
                nOut++;
                lastOutCyc = cyc;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out_valid", 32'(outValid), 32'd0);
                end else begin
                    expEntry_t e;
                    e = sb.pop_front();
                    checkOutput("out_data", 32'(outData), 32'(e.value));
                    checkOutput("out_valid_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic startJob(input logic [CNT_BW-1:0] n);
        @(posedge clk); #1;
        nOut   = 0;
        start  = 1'b1;
        numVec = n;
        @(posedge clk); #1;
        start  = 1'b0;
        numVec = '0;
    endtask

    task automatic sendWeights(input logic [WW-1:0] w);
        bit got = 0;
        tbWeights = w;
        wtValid   = 1'b1;
        wtData    = w;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (wtReady) got = 1;
        end
        checkOutput("wt_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        wtValid = 1'b0;
        @(negedge clk);
        checkOutput("reload_pulse", 32'(peReload), 32'd1);
        checkOutput("reload_in_ready", 32'(inReady), 32'd0);
        checkOutput("reload_weights", 32'(peWeights == w), 32'd1);
        @(negedge clk);
        checkOutput("reload_single", 32'(peReload), 32'd0);
        checkOutput("stream_in_ready", 32'(inReady), 32'd1);
    endtask

    task automatic applyStimulus(input logic [VW-1:0] d, input int n, input int gapIdx, input int gapLen);
        for (int k = 0; k < n; k++) begin
            bit got = 0;
            @(posedge clk); #1;
            if (k == gapIdx) begin
                inValid = 1'b0;
                repeat (gapLen) @(posedge clk);
                #1;
            end
            inValid = 1'b1;
            inData  = d;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (inReady) got = 1;
            end
            checkOutput("in_handshake", 32'(got), 32'd1);
        end
        @(posedge clk); #1;
        inValid = 1'b0;
        inData  = '0;
    endtask

    task automatic waitDone(input int expOut);
        bit got = 0;
        int doneCyc = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                doneCyc = cyc;
            end
        end
        checkOutput("done_seen", 32'(got), 32'd1);
        checkOutput("done_after_last_out", 32'(doneCyc), 32'(lastOutCyc + 1));
        checkOutput("result_count", 32'(nOut), 32'(expOut));
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        checkOutput("idle_after_done", 32'({busy, done}), 32'd0);
    endtask

    initial begin
        logic [WW-1:0] wOnes, wRamp, wNeg;
        logic [VW-1:0] dOnes, dTwos, dThrees;
        int doneBefore;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            wOnes[i*8 +: 8]   = 8'd1;
            wRamp[i*8 +: 8]   = 8'(i + 1);
            wNeg[i*8 +: 8]    = 8'hFF;
            dOnes[i*8 +: 8]   = 8'd1;
            dTwos[i*8 +: 8]   = 8'd2;
            dThrees[i*8 +: 8] = 8'd3;
        end

        // Reset with random inputs
        rstn = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            start   = 1'($urandom);
            numVec  = CNT_BW'($urandom);
            wtValid = 1'($urandom);
            wtData  = {$urandom, $urandom};
            inValid = 1'($urandom);
            inData  = {$urandom, $urandom};
            @(negedge clk);
            checkOutput("rst_flags", 32'({wtReady, inReady, peReload, outValid, busy, done}), 32'd0);
            checkOutput("rst_weights", 32'(peWeights != '0), 32'd0);
            checkOutput("rst_data_in", 32'(peDataIn != '0), 32'd0);
        end
        start = 1'b0; numVec = '0; wtValid = 1'b0; wtData = '0; inValid = 1'b0; inData = '0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_idle", 32'({wtReady, inReady, busy, done}), 32'd0);

        $display("[TB] basic job");
        startJob(3);
        sendWeights(wOnes);
        applyStimulus(dTwos, 3, -1, 0);
        waitDone(3);

        $display("[TB] bubbles");
        startJob(4);
        sendWeights(wRamp);
        applyStimulus(dOnes, 4, 2, 2);
        waitDone(4);

        $display("[TB] zero length");
        doneBefore = nDone;
        startJob(0);
        @(negedge clk);
        checkOutput("zero_done", 32'({done, busy}), 32'b11);
        checkOutput("zero_no_hs", 32'({wtReady, inReady, peReload}), 32'd0);
        @(negedge clk);
        checkOutput("zero_idle", 32'({wtReady, inReady, peReload, busy, done}), 32'd0);
        checkOutput("zero_one_done", 32'(nDone - doneBefore), 32'd1);

        $display("[TB] reset mid stream");
        startJob(5);
        sendWeights(wOnes);
        applyStimulus(dTwos, 2, -1, 0);
        doneBefore = nDone;
        rstn = 1'b0;
        #1;
        checkOutput("abort_flags", 32'({wtReady, inReady, peReload, outValid, busy, done}), 32'd0);
        checkOutput("abort_regs", 32'((peWeights != '0) || (peDataIn != '0)), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("abort_no_done", 32'(nDone - doneBefore), 32'd0);
        checkOutput("abort_idle", 32'(busy), 32'd0);
        startJob(1);
        sendWeights(wRamp);
        applyStimulus(dTwos, 1, -1, 0);
        waitDone(1);

        $display("[TB] back to back");
        startJob(2);
        sendWeights(wOnes);
        @(posedge clk); #1;
        start = 1'b1; numVec = CNT_BW'(7);
        @(posedge clk); #1;
        start = 1'b0; numVec = '0;
        applyStimulus(dTwos, 2, -1, 0);
        waitDone(2);
        startJob(1);
        sendWeights(wNeg);
        applyStimulus(dThrees, 1, -1, 0);
        waitDone(1);
        checkOutput("weights_hold", 32'(peWeights == wNeg), 32'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
